// File: rtl/morse_pkg.sv
// Shared types and defaults for the Morse symbol sequencer.
package morse_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ELEM  = 3'd1,
      S_EWAIT = 3'd2,
      S_SPACE = 3'd3,
      S_SWAIT = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      P_NONE = 3'd0,
      P_DOT  = 3'd1,
      P_DASH = 3'd2,
      P_CHAR = 3'd3,
      P_WORD = 3'd4
   } pulse_e;

   localparam int DOT_HOLD_DEF  = 2;
   localparam int CHAR_HOLD_DEF = 4;
   localparam int WORD_HOLD_DEF = 8;
   localparam int SYM_W         = 9;
   localparam int HOLD_W        = 8;

   // One queued character: element count, element bits (LSB first), terminator kind.
   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pattern;
      logic       word_end;
   } sym_t;

   // Element counts above five are treated as five.
   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      return (len > 3'd5) ? 3'd5 : len;
   endfunction

endpackage

// File: rtl/morse_sym_fifo.sv
// Small synchronous FIFO holding queued Morse characters.
// A push is refused when full even if a pop happens in the same cycle.
module morse_sym_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   // Storage write; no reset needed because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally modulo DEPTH; flush empties the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/morse_sequencer.sv
// Turns queued Morse characters into single-cycle dot/dash/space requests
// while enforcing minimum spacing between consecutive requests.
module morse_sequencer
   import morse_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int DOT_HOLD  = DOT_HOLD_DEF,
   parameter int CHAR_HOLD = CHAR_HOLD_DEF,
   parameter int WORD_HOLD = WORD_HOLD_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_len,
   input  logic [4:0] in_pattern,
   input  logic       in_word_end,
   input  logic       flush,
   output logic       dot_out,
   output logic       dash_out,
   output logic       char_space_out,
   output logic       word_space_out,
   output logic       busy
);
   // Wait-state lengths: the next pulse lands exactly HOLD cycles after the last.
   localparam logic [HOLD_W-1:0] DOT_LOAD  = HOLD_W'(DOT_HOLD - 2);
   localparam logic [HOLD_W-1:0] CHAR_LOAD = HOLD_W'(CHAR_HOLD - 3);
   localparam logic [HOLD_W-1:0] WORD_LOAD = HOLD_W'(WORD_HOLD - 3);

   sym_t              wr_sym;
   sym_t              head;
   logic              fifo_empty;
   logic              fifo_full;
   logic              pop;
   state_e            state, state_next;
   pulse_e            pulse_next;
   logic [HOLD_W-1:0] cnt, cnt_next;
   logic [2:0]        idx, idx_next, idx_inc;
   logic [2:0]        len, len_next;
   logic [4:0]        pattern, pattern_next;
   logic              word_end, word_end_next;

   assign wr_sym   = '{len: clamp_len(in_len), pattern: in_pattern, word_end: in_word_end};
   assign in_ready = !fifo_full;
   assign busy     = (state != S_IDLE) || !fifo_empty;
   assign idx_inc  = idx + 3'd1;

   morse_sym_fifo #(.DEPTH(DEPTH), .WIDTH(SYM_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (in_valid),
      .wdata (wr_sym),
      .pop   (pop),
      .rdata (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Next-state logic; pulses are decided on entry to S_ELEM/S_SPACE so they can be registered.
   always_comb begin
      state_next    = state;
      pulse_next    = P_NONE;
      cnt_next      = cnt;
      idx_next      = idx;
      len_next      = len;
      pattern_next  = pattern;
      word_end_next = word_end;
      pop           = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop           = 1'b1;
               len_next      = head.len;
               pattern_next  = head.pattern;
               word_end_next = head.word_end;
               idx_next      = 3'd0;
               if (head.len != 3'd0) begin
                  state_next = S_ELEM;
                  pulse_next = head.pattern[0] ? P_DASH : P_DOT;
               end else begin
                  state_next = S_SPACE;
                  pulse_next = head.word_end ? P_WORD : P_CHAR;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         S_ELEM: begin
            cnt_next   = DOT_LOAD;
            state_next = S_EWAIT;
         end
         S_EWAIT: begin
            if (cnt != '0) begin
               cnt_next = cnt - HOLD_W'(1);
            end else if (idx_inc < len) begin
               idx_next   = idx_inc;
               state_next = S_ELEM;
               pulse_next = pattern[idx_inc] ? P_DASH : P_DOT;
            end else begin
               state_next = S_SPACE;
               pulse_next = word_end ? P_WORD : P_CHAR;
            end
         end
         S_SPACE: begin
            cnt_next   = word_end ? WORD_LOAD : CHAR_LOAD;
            state_next = S_SWAIT;
         end
         S_SWAIT: begin
            if (cnt != '0) begin
               cnt_next = cnt - HOLD_W'(1);
            end else begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      if (flush) begin
         state_next = S_IDLE;
         pulse_next = P_NONE;
         cnt_next   = '0;
         idx_next   = 3'd0;
         pop        = 1'b0;
      end else begin
         pop = pop;
      end
   end

   // State, working registers and registered request pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         idx            <= 3'd0;
         len            <= 3'd0;
         pattern        <= 5'd0;
         word_end       <= 1'b0;
         dot_out        <= 1'b0;
         dash_out       <= 1'b0;
         char_space_out <= 1'b0;
         word_space_out <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         idx            <= idx_next;
         len            <= len_next;
         pattern        <= pattern_next;
         word_end       <= word_end_next;
         dot_out        <= (pulse_next == P_DOT);
         dash_out       <= (pulse_next == P_DASH);
         char_space_out <= (pulse_next == P_CHAR);
         word_space_out <= (pulse_next == P_WORD);
      end
   end

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer: a timeline model predicts every
// pulse cycle, FIFO occupancy and busy window from the hold rules.
module tb_morse_sequencer;
   localparam int DEPTH  = 4;
   localparam int DOT_H  = 2;
   localparam int CHAR_H = 4;
   localparam int WORD_H = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_len = 3'd0;
   logic [4:0] in_pattern = 5'd0;
   logic       in_word_end = 1'b0;
   logic       flush = 1'b0;
   logic       dot_out, dash_out, char_space_out, word_space_out, busy;
   logic [5:0] obs;

   morse_sequencer #(.DEPTH(DEPTH), .DOT_HOLD(DOT_H), .CHAR_HOLD(CHAR_H), .WORD_HOLD(WORD_H)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_len         (in_len),
      .in_pattern     (in_pattern),
      .in_word_end    (in_word_end),
      .flush          (flush),
      .dot_out        (dot_out),
      .dash_out       (dash_out),
      .char_space_out (char_space_out),
      .word_space_out (word_space_out),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   assign obs = {dot_out, dash_out, char_space_out, word_space_out, in_ready, busy};

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Timeline model: accept cycles, pop cycles, active windows, pulse schedule.
   int acc_q[$];
   int pop_q[$];
   int lo_q[$];
   int hi_q[$];
   int exp_pulse[int];   // 1 dot, 2 dash, 3 char space, 4 word space
   int next_allowed = 0;

   function automatic void model_clear();
      acc_q.delete();
      pop_q.delete();
      lo_q.delete();
      hi_q.delete();
      exp_pulse.delete();
      next_allowed = 0;
   endfunction

   function automatic int fifo_cnt(int c);
      int n = 0;
      foreach (acc_q[i]) if (acc_q[i] < c) n++;
      foreach (pop_q[i]) if (pop_q[i] < c) n--;
      return n;
   endfunction

   function automatic void model_accept(int a, int len, logic [4:0] pat, logic we);
      int l, start, sp, hold;
      l = (len > 5) ? 5 : len;
      start = (a + 2 > next_allowed) ? a + 2 : next_allowed;
      acc_q.push_back(a);
      pop_q.push_back(start - 1);
      for (int i = 0; i < l; i++) exp_pulse[start + i * DOT_H] = pat[i] ? 2 : 1;
      sp = start + l * DOT_H;
      exp_pulse[sp] = we ? 4 : 3;
      hold = we ? WORD_H : CHAR_H;
      next_allowed = sp + hold;
      lo_q.push_back(start);
      hi_q.push_back(sp + hold - 2);
   endfunction

   function automatic logic [5:0] exp_vec(int c);
      int code;
      logic act;
      code = exp_pulse.exists(c) ? exp_pulse[c] : 0;
      act = (fifo_cnt(c) > 0);
      foreach (lo_q[i]) if (c >= lo_q[i] && c <= hi_q[i]) act = 1'b1;
      return {code == 1, code == 2, code == 3, code == 4, fifo_cnt(c) < DEPTH, act};
   endfunction

   // Apply current inputs for one cycle, update the model, land on the next falling edge.
   task automatic tick();
      if (!rst && flush) begin
         model_clear();
      end else if (!rst && in_valid && fifo_cnt(cyc) < DEPTH) begin
         model_accept(cyc, int'(in_len), in_pattern, in_word_end);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 6'b000010) begin
         failures++;
         $display("FAIL reset_state got=%b want=%b", obs, 6'b000010);
      end
      rst = 1'b0;
      model_clear();
      cyc = 0;
      tick();
      checks++;
      if (obs !== 6'b000010) begin
         failures++;
         $display("FAIL post_reset_idle got=%b want=%b", obs, 6'b000010);
      end
   endtask

   task automatic test_letter_a();
      int a, k;
      logic [3:0] lit;
      a = cyc;
      in_valid = 1'b1; in_len = 3'd2; in_pattern = 5'b00010; in_word_end = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (14) begin
         k = cyc - a;
         checks++;
         if (obs !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL letter_a_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec(cyc));
         end
         lit = (k == 2) ? 4'b1000 : (k == 4) ? 4'b0100 : (k == 6) ? 4'b0010 : 4'b0000;
         checks++;
         if (obs[5:2] !== lit) begin
            failures++;
            $display("FAIL letter_a_pulse k=%0d got=%b want=%b", k, obs[5:2], lit);
         end
         if (k >= 10 || k <= 8) begin
            checks++;
            if (busy !== (k <= 8)) begin
               failures++;
               $display("FAIL letter_a_busy k=%0d got=%b want=%b", k, busy, (k <= 8));
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int a, k;
      logic [3:0] lit;
      a = cyc;
      in_valid = 1'b1; in_len = 3'd1; in_pattern = 5'b00000; in_word_end = 1'b1;
      tick();
      in_len = 3'd1; in_pattern = 5'b00001; in_word_end = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (22) begin
         k = cyc - a;
         checks++;
         if (obs !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL b2b_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec(cyc));
         end
         lit = (k == 2) ? 4'b1000 : (k == 4) ? 4'b0001 : (k == 12) ? 4'b0100 :
               (k == 14) ? 4'b0010 : 4'b0000;
         checks++;
         if (obs[5:2] !== lit) begin
            failures++;
            $display("FAIL b2b_pulse k=%0d got=%b want=%b", k, obs[5:2], lit);
         end
         tick();
      end
   endtask

   task automatic test_full();
      int a;
      a = cyc;
      for (int k = 0; k < 130; k++) begin
         if (k > 0) begin
            checks++;
            if (obs !== exp_vec(cyc)) begin
               failures++;
               $display("FAIL full_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec(cyc));
            end
         end
         if (k == 5 || k == 19 || k == 20) begin
            checks++;
            if (in_ready !== (k == 20)) begin
               failures++;
               $display("FAIL full_ready k=%0d got=%b want=%b", k, in_ready, (k == 20));
            end
         end
         in_valid    = (k <= 20);
         in_len      = (k == 0) ? 3'd5 : 3'($urandom_range(0, 7));
         in_pattern  = 5'($urandom);
         in_word_end = (k == 0) ? 1'b1 : 1'($urandom);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_len_zero();
      int a, k;
      logic [3:0] lit;
      a = cyc;
      in_valid = 1'b1; in_len = 3'd0; in_pattern = 5'b10101; in_word_end = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (12) begin
         k = cyc - a;
         lit = (k == 2) ? 4'b0001 : 4'b0000;
         checks++;
         if (obs[5:2] !== lit || obs !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL len_zero k=%0d got=%b want=%b model=%b", k, obs[5:2], lit, exp_vec(cyc));
         end
         tick();
      end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 16; k++) begin
         if (k > 0) begin
            checks++;
            if (obs !== exp_vec(cyc)) begin
               failures++;
               $display("FAIL flush_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec(cyc));
            end
         end
         if (k >= 6) begin
            checks++;
            if (obs !== 6'b000010) begin
               failures++;
               $display("FAIL flush_quiet k=%0d got=%b want=%b", k, obs, 6'b000010);
            end
         end
         in_valid    = (k <= 3);
         in_len      = 3'd5;
         in_pattern  = 5'($urandom);
         in_word_end = 1'($urandom);
         flush       = (k == 5);
         tick();
      end
      in_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_rst_mid();
      int a, b, k;
      logic [3:0] lit;
      a = cyc;
      in_valid = 1'b1; in_len = 3'd2; in_pattern = 5'b00010; in_word_end = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         checks++;
         if (obs !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL rst_mid_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec(cyc));
         end
         if (j < 5) tick();
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 6'b000010) begin
         failures++;
         $display("FAIL rst_mid_async got=%b want=%b", obs, 6'b000010);
      end
      model_clear();
      tick();
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (obs !== 6'b000010) begin
            failures++;
            $display("FAIL rst_mid_quiet cyc=%0d got=%b want=%b", cyc, obs, 6'b000010);
         end
         tick();
      end
      b = cyc;
      in_valid = 1'b1; in_len = 3'd1; in_pattern = 5'b00001; in_word_end = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (8) begin
         k = cyc - b;
         lit = (k == 2) ? 4'b0100 : (k == 4) ? 4'b0010 : 4'b0000;
         checks++;
         if (obs[5:2] !== lit || obs !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL rst_fresh k=%0d got=%b want=%b model=%b", k, obs[5:2], lit, exp_vec(cyc));
         end
         tick();
      end
      if (a < 0) $display("unreachable");
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         checks++;
         if (obs !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec(cyc));
         end
         in_valid    = (k < 700) && ($urandom_range(0, 2) == 0);
         in_len      = 3'($urandom_range(0, 7));
         in_pattern  = 5'($urandom);
         in_word_end = 1'($urandom);
         flush       = (k < 700) && ($urandom_range(0, 80) == 0);
         tick();
      end
      in_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (obs !== 6'b000010) begin
         failures++;
         $display("FAIL random_drained got=%b want=%b", obs, 6'b000010);
      end
   endtask

   initial begin
      test_reset();
      test_letter_a();
      test_back_to_back();
      test_full();
      test_len_zero();
      test_flush();
      test_rst_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, symbol FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameters DOT_HOLD=2, CHAR_HOLD=4, WORD_HOLD=8: minimum cycles from one issued pulse to the next pulse.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  character entry offered.
REQ-006 in_ready  output  1  entry accepted when in_valid&in_ready.
REQ-007 in_len  input  3  element count 0..5; values 6..7 are treated as 5.
REQ-008 in_pattern  input  5  element i (bit i, LSB sent first): 0=dot, 1=dash.
REQ-009 in_word_end  input  1  1: terminate character with word space; 0: with char space.
REQ-010 flush  input  1  synchronous abort: empty FIFO, drop current character.
REQ-011 dot_out, dash_out, char_space_out, word_space_out  output  1 each  single-cycle request pulses to the Morse transmit FSM.
REQ-012 busy  output  1  high when FIFO non-empty or sequencer not in S_IDLE.

Function
REQ-013 Pulse outputs SHALL be mutually exclusive, and each SHALL be high for exactly one cycle per issue.
REQ-014 in_ready SHALL equal !full; a push is refused when full, even if a pop occurs in the same cycle.
REQ-015 The FSM SHALL have states S_IDLE, S_ELEM, S_EWAIT, S_SPACE, S_SWAIT.
REQ-016 S_IDLE: if FIFO non-empty, pop into working regs (len, pattern, word_end, idx=0); go S_ELEM if len>0, else S_SPACE.
REQ-017 S_ELEM: pulse dash_out if pattern[idx], else dot_out; load hold counter; go S_EWAIT.
REQ-018 S_EWAIT: count down; exit so the next pulse lands exactly DOT_HOLD cycles after the element pulse; go S_ELEM with idx+1 if idx+1<len, else S_SPACE.
REQ-019 S_SPACE: pulse word_space_out if word_end, else char_space_out; go S_SWAIT.
REQ-020 S_SWAIT: return to S_IDLE so the earliest next pulse is WORD_HOLD or CHAR_HOLD cycles after the space pulse.
REQ-021 Latency: for an entry accepted at cycle a into an empty, idle block, the first pulse SHALL occur at a+2.
REQ-022 Back-to-back entries: no idle gap beyond the hold rules; the pop in S_IDLE occurs on the cycle the hold expires.
REQ-023 Simultaneous push and pop on a non-full FIFO SHALL both succeed, with the count unchanged.
REQ-024 flush SHALL have priority over push, pop and FSM advance; next cycle: FIFO empty, state S_IDLE, no pulse issued in the flush cycle.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; the count register is log2(DEPTH)+1 bits.

Reset
REQ-026 On rst: state S_IDLE, FIFO empty, counters/idx 0, all pulses 0, busy 0, in_ready 1.
REQ-027 rst asserted mid-character SHALL abort immediately with no further pulses; after release, behaviour is as after power-up.

Structure
REQ-028 State encodings, hold defaults and pulse codes SHALL live in shared package morse_pkg.
REQ-029 FIFO SHALL be sub-module morse_sym_fifo (width 9: len, pattern, word_end); the FSM and hold counter stay in morse_sequencer.

Verification
REQ-030 Push 'A' (len=2, pattern=00010, word_end=0) at cycle a -> dot a+2, dash a+4, char_space a+6, busy low from a+10.
REQ-031 Push 'E' (len=1, pattern=0, word_end=1) then 'T' (len=1, pattern=1, word_end=0) back-to-back -> dot T0, word_space T0+2, dash T0+10, char_space T0+12.
REQ-032 Hold in_valid with no pops for 5 entries (DEPTH=4) -> in_ready low after the 4th accept; the 5th entry is accepted only after the first pop.
REQ-033 len=0, word_end=1 -> only word_space_out at a+2, no dot/dash.
REQ-034 flush during S_EWAIT of a 5-element entry with 3 queued -> no pulses after flush, busy 0 next cycle, in_ready 1.
REQ-035 rst pulsed between dash and char_space -> no char_space issued; a fresh push afterwards gives first pulse at a+2.
